// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package reg_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [4:0]  ZERO_REG   = 5'd0;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundles the two writeback requesters, the stall input and the register-file write port.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic                AValid;
  logic [ADDR_W-1:0]   AAddr;
  logic [DATA_W-1:0]   AData;
  logic                AReady;
  logic                BValid;
  logic [ADDR_W-1:0]   BAddr;
  logic [DATA_W-1:0]   BData;
  logic                BReady;
  logic                Stall;
  logic                RegWrite;
  logic [ADDR_W-1:0]   WriteRegister;
  logic [DATA_W-1:0]   WriteData;
  logic [NUM_REGS-1:0] Busy;

  modport slave (
    input  AValid, AAddr, AData, BValid, BAddr, BData, Stall,
    output AReady, BReady, RegWrite, WriteRegister, WriteData, Busy
  );

  modport master (
    output AValid, AAddr, AData, BValid, BAddr, BData, Stall,
    input  AReady, BReady, RegWrite, WriteRegister, WriteData, Busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; Grant doubles as the ready signal (bit 0 = A, bit 1 = B).
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] Valid,
  input  logic       Stall,
  input  req_e       LastGrant,
  output logic [1:0] Grant
);

  always_comb begin
    Grant = '0;
    if (!Stall) begin
      unique case (Valid)
        2'b01:   Grant = 2'b01;
        2'b10:   Grant = 2'b10;
        2'b11:   Grant = (LastGrant == REQ_B) ? 2'b01 : 2'b10;
        // Idle: A is kept ready so a fresh ALU writeback is taken without delay.
        default: Grant = 2'b01;
      endcase
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates pipeline (A) and multi-cycle (B) writebacks onto the register-file write
// port, registering the winner and tracking in-flight destinations in Busy.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                Clk,
  input logic                Rst,
  reg_write_arbiter_if.slave bus
);

  req_e                r_last_grant;
  logic                r_reg_write;
  logic [ADDR_W-1:0]   r_write_reg;
  logic [DATA_W-1:0]   r_write_data;
  logic [NUM_REGS-1:0] r_busy;

  logic [1:0]          w_grant;
  logic                w_acc_a;
  logic                w_acc_b;
  logic                w_acc;
  logic                w_nonzero;
  req_e                w_winner;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [NUM_REGS-1:0] w_busy_next;

  rr_arb2 u_arb (
    .Valid     ({bus.BValid, bus.AValid}),
    .Stall     (bus.Stall),
    .LastGrant (r_last_grant),
    .Grant     (w_grant)
  );

  assign bus.AReady        = w_grant[0];
  assign bus.BReady        = w_grant[1];
  assign bus.RegWrite      = r_reg_write;
  assign bus.WriteRegister = r_write_reg;
  assign bus.WriteData     = r_write_data;
  assign bus.Busy          = r_busy;

  always_comb begin
    w_acc_a   = bus.AValid & w_grant[0];
    w_acc_b   = bus.BValid & w_grant[1];
    w_acc     = w_acc_a | w_acc_b;
    w_winner  = w_acc_b ? REQ_B : REQ_A;
    w_addr    = w_acc_b ? bus.BAddr : bus.AAddr;
    w_data    = w_acc_b ? bus.BData : bus.AData;
    w_nonzero = (w_addr != ADDR_W'(ZERO_REG));

    // Clear on commit first, then set, so a back-to-back write to the same register keeps it busy.
    w_busy_next = r_busy;
    if (r_reg_write) begin
      w_busy_next[r_write_reg] = 1'b0;
    end
    if (w_acc && w_nonzero) begin
      w_busy_next[w_addr] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_last_grant <= REQ_B;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_busy       <= '0;
    end else begin
      r_reg_write <= w_acc & w_nonzero;
      r_busy      <= w_busy_next;
      if (w_acc) begin
        r_last_grant <= w_winner;
        r_write_reg  <= w_addr;
        r_write_data <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter with a commit scoreboard.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wr_t         exp_q[$];
  bit          lg_b;
  logic [31:0] exp_busy;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;

  reg_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  reg_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: writes leave in acceptance order, Busy holds only the register
  // accepted at the most recent edge, and round-robin favours the side not last served.
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input bit st, input bit rs, output bit acc_a, output bit acc_b);
    bit ra, rb, exp_rw;
    wr_t w;
    @(negedge clk);
    bus.AValid = av; bus.AAddr = aa; bus.AData = ad;
    bus.BValid = bv; bus.BAddr = ba; bus.BData = bd;
    bus.Stall  = st; rst = rs;
    #1;
    if (st)            begin ra = 0;     rb = 0;     end
    else if (av && bv) begin ra = lg_b;  rb = !lg_b; end
    else if (bv)       begin ra = 0;     rb = 1;     end
    else               begin ra = 1;     rb = 0;     end
    chk("AReady", {31'b0, bus.AReady}, {31'b0, ra});
    chk("BReady", {31'b0, bus.BReady}, {31'b0, rb});
    acc_a  = av && ra && !rs;
    acc_b  = bv && rb && !rs;
    exp_rw = 0;
    if (rs) begin
      lg_b = 1; exp_busy = '0; exp_wreg = '0; exp_wdata = '0;
    end else if (acc_a || acc_b) begin
      w.addr = acc_a ? aa : ba;
      w.data = acc_a ? ad : bd;
      lg_b = acc_b;
      exp_wreg = w.addr;
      exp_wdata = w.data;
      exp_busy = (w.addr != 0) ? (32'd1 << w.addr) : 32'd0;
      if (w.addr != 0) begin
        exp_q.push_back(w);
        exp_rw = 1;
      end
    end else begin
      exp_busy = '0;
    end
    @(posedge clk);
    #2;
    chk("RegWrite", {31'b0, bus.RegWrite}, {31'b0, exp_rw});
    chk("Busy", bus.Busy, exp_busy);
    chk("WriteRegister", {27'b0, bus.WriteRegister}, {27'b0, exp_wreg});
    chk("WriteData", bus.WriteData, exp_wdata);
  endtask

  // Commit monitor: every RegWrite pulse must match the oldest accepted write.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (bus.RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected: got write to %0d expected none", bus.WriteRegister);
        end else begin
          w = exp_q.pop_front();
          chk("commit_addr", {27'b0, bus.WriteRegister}, {27'b0, w.addr});
          chk("commit_data", bus.WriteData, w.data);
        end
      end
    end
  end

  initial begin
    bit a, b;
    bit ha_v, hb_v;
    logic [4:0]  ha_a, hb_a;
    logic [31:0] ha_d, hb_d;
    checks = 0; errors = 0;
    lg_b = 1; exp_busy = '0; exp_wreg = '0; exp_wdata = '0;
    rst = 1'b1;
    bus.AValid = 0; bus.AAddr = '0; bus.AData = '0;
    bus.BValid = 0; bus.BAddr = '0; bus.BData = '0;
    bus.Stall = 0;

    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);

    // Single A write, then idle to let it commit.
    step(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);

    // Continuous contention from reset alternates A,B,A,B.
    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    for (int i = 0; i < 4; i++)
      step(1, 9, 32'h900 + i, 1, 10, 32'hA00 + i, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);

    // Same destination from both sides.
    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    step(1, 12, 32'd1, 1, 12, 32'd2, 0, 0, a, b);
    step(0, 0, 0, 1, 12, 32'd2, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);

    // Write to $zero is accepted but discarded.
    step(1, 0, 32'd5, 0, 0, 0, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);

    // Stall blocks everything; A wins once released.
    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    for (int i = 0; i < 3; i++)
      step(1, 3, 32'h33, 1, 4, 32'h44, 1, 0, a, b);
    step(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, a, b);
    step(0, 0, 0, 1, 4, 32'h44, 0, 0, a, b);

    // Reset right after a B acceptance.
    step(0, 0, 0, 1, 17, 32'h1717, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    step(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, a, b);
    step(0, 0, 0, 1, 6, 32'h66, 0, 0, a, b);

    // Randomized traffic; each requester holds its request until accepted.
    ha_v = 0; hb_v = 0; ha_a = 0; hb_a = 0; ha_d = 0; hb_d = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!ha_v && ($urandom % 3 != 0)) begin
        ha_v = 1; ha_a = 5'($urandom_range(0, 15)); ha_d = $urandom;
      end
      if (!hb_v && ($urandom % 3 == 0)) begin
        hb_v = 1; hb_a = 5'($urandom_range(0, 15)); hb_d = $urandom;
      end
      step(ha_v, ha_a, ha_d, hb_v, hb_a, hb_d,
           ($urandom % 6 == 0), ($urandom % 50 == 0), a, b);
      if (a) ha_v = 0;
      if (b) hb_v = 0;
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, b);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
